// File: rtl/pid_error_stage_if.sv
// Handshake bundle between the error source, the PID error stage and the downstream adders.
// The stage uses the slave modport; whoever feeds samples and consumes terms uses master.
interface pid_error_stage_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
);
    logic                         err_valid;
    logic                         err_ready;
    logic signed [DATA_WIDTH-1:0] err_in;
    logic                         clear_in;
    logic                         hold_in;
    logic signed [DATA_WIDTH-1:0] p_out;
    logic signed [ACC_WIDTH-1:0]  i_out;
    logic signed [DATA_WIDTH:0]   d_out;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output err_valid, err_in, clear_in, hold_in, out_ready,
        input  err_ready, p_out, i_out, d_out, out_valid
    );

    modport slave (
        input  err_valid, err_in, clear_in, hold_in, out_ready,
        output err_ready, p_out, i_out, d_out, out_valid
    );
endinterface

// File: rtl/pid_error_stage.sv
// Splits each signed error sample into P, I (clamped running sum, freezable) and D
// (first difference) terms, one sample per IDLE -> CALC -> OUT pass.
module pid_error_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int INT_LIMIT  = 2**(ACC_WIDTH-1)-1
) (
    input logic              clk,
    input logic              rst_n,
    pid_error_stage_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    localparam logic signed [ACC_WIDTH:0] LIM_POS = (ACC_WIDTH+1)'(INT_LIMIT);
    localparam logic signed [ACC_WIDTH:0] LIM_NEG = -LIM_POS;

    state_t                       state_reg,    state_next;
    logic signed [ACC_WIDTH-1:0]  acc_reg,      acc_next;
    logic signed [DATA_WIDTH-1:0] prev_err_reg, prev_err_next;
    logic                         first_reg,    first_next;
    logic signed [DATA_WIDTH-1:0] err_lat_reg,  err_lat_next;
    logic                         hold_lat_reg, hold_lat_next;
    logic signed [DATA_WIDTH-1:0] p_reg,        p_next;
    logic signed [ACC_WIDTH-1:0]  i_reg,        i_next;
    logic signed [DATA_WIDTH:0]   d_reg,        d_next;

    logic signed [ACC_WIDTH:0]    sum_w;
    logic signed [ACC_WIDTH:0]    acc_clamped;
    logic signed [DATA_WIDTH:0]   diff_w;

    // One guard bit keeps the sum exact so the clamp sees the true value.
    assign sum_w  = (ACC_WIDTH+1)'(acc_reg) + (ACC_WIDTH+1)'(err_lat_reg);
    assign diff_w = (DATA_WIDTH+1)'(err_lat_reg) - (DATA_WIDTH+1)'(prev_err_reg);

    always_comb begin
        acc_clamped = sum_w;
        if (sum_w > LIM_POS) begin
            acc_clamped = LIM_POS;
        end else if (sum_w < LIM_NEG) begin
            acc_clamped = LIM_NEG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            prev_err_reg <= '0;
            first_reg    <= 1'b1;
            err_lat_reg  <= '0;
            hold_lat_reg <= 1'b0;
            p_reg        <= '0;
            i_reg        <= '0;
            d_reg        <= '0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            prev_err_reg <= prev_err_next;
            first_reg    <= first_next;
            err_lat_reg  <= err_lat_next;
            hold_lat_reg <= hold_lat_next;
            p_reg        <= p_next;
            i_reg        <= i_next;
            d_reg        <= d_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        prev_err_next = prev_err_reg;
        first_next    = first_reg;
        err_lat_next  = err_lat_reg;
        hold_lat_next = hold_lat_reg;
        p_next        = p_reg;
        i_next        = i_reg;
        d_next        = d_reg;

        // Clear overrides everything, including a sample offered in the same cycle.
        if (bus.clear_in) begin
            state_next    = IDLE;
            acc_next      = '0;
            prev_err_next = '0;
            first_next    = 1'b1;
            p_next        = '0;
            i_next        = '0;
            d_next        = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.err_valid) begin
                        err_lat_next  = bus.err_in;
                        hold_lat_next = bus.hold_in;
                        state_next    = CALC;
                    end
                end
                CALC: begin
                    // A frozen integral still advances the derivative history.
                    if (!hold_lat_reg) begin
                        acc_next = acc_clamped[ACC_WIDTH-1:0];
                        i_next   = acc_clamped[ACC_WIDTH-1:0];
                    end else begin
                        i_next   = acc_reg;
                    end
                    p_next        = err_lat_reg;
                    d_next        = first_reg ? '0 : diff_w;
                    prev_err_next = err_lat_reg;
                    first_next    = 1'b0;
                    state_next    = OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.err_ready = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == OUT);
    assign bus.p_out     = p_reg;
    assign bus.i_out     = i_reg;
    assign bus.d_out     = d_reg;

endmodule
